// File: rtl/cobra_ctrl.sv
// Snake head movement sequencer: tick divider, reversal filter, run/pause/dead FSM.
// Define COBRA_WRAP_EN to make the grid edges wrap instead of ending the game.
module cobra_ctrl #(
    parameter int GRID_W   = 32,
    parameter int GRID_H   = 24,
    parameter int XW       = 5,
    parameter int YW       = 5,
    parameter int TICK_DIV = 5000000
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          pause,
    input  logic          dir_valid,
    input  logic [1:0]    dir_in,
    output logic [XW-1:0] head_x,
    output logic [YW-1:0] head_y,
    output logic [1:0]    cur_dir,
    output logic          step,
    output logic          crash,
    output logic [1:0]    state
);

    localparam int CW = $clog2(TICK_DIV);

    localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);
    localparam logic [XW-1:0] X_HOME    = XW'(GRID_W / 2);
    localparam logic [YW-1:0] Y_HOME    = YW'(GRID_H / 2);
    localparam logic [XW-1:0] X_LAST    = XW'(GRID_W - 1);
    localparam logic [YW-1:0] Y_LAST    = YW'(GRID_H - 1);

    localparam logic [1:0] D_UP    = 2'b00;
    localparam logic [1:0] D_DOWN  = 2'b01;
    localparam logic [1:0] D_LEFT  = 2'b10;
    localparam logic [1:0] D_RIGHT = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_PAUSE = 2'b10,
        S_DEAD  = 2'b11
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [XW-1:0] hx_q, hx_d;
    logic [YW-1:0] hy_q, hy_d;
    logic [1:0]    dir_q, dir_d;
    logic [1:0]    pend_q, pend_d;
    logic          step_q, step_d;
    logic          crash_q, crash_d;

    logic          tick;
    logic [1:0]    ref_dir;
    logic          dir_ok;
    logic [XW-1:0] nx;
    logic [YW-1:0] ny;
    logic          wall;

    // Same-axis, opposite-sense codes differ only in bit 0.
    function automatic logic is_rev(input logic [1:0] req,
                                    input logic [1:0] d);
        return (req[1] == d[1]) && (req[0] != d[0]);
    endfunction

    assign tick    = (state_q == S_RUN) && (cnt_q == TICK_LAST);
    // On the tick cycle the pending direction is the one being committed.
    assign ref_dir = tick ? pend_q : dir_q;
    assign dir_ok  = dir_valid && !is_rev(dir_in, ref_dir);

    always_comb begin
        nx   = hx_q;
        ny   = hy_q;
        wall = 1'b0;
`ifdef COBRA_WRAP_EN
        unique case (pend_q)
            D_UP:    ny = (hy_q == '0)     ? Y_LAST : hy_q - YW'(1);
            D_DOWN:  ny = (hy_q == Y_LAST) ? '0     : hy_q + YW'(1);
            D_LEFT:  nx = (hx_q == '0)     ? X_LAST : hx_q - XW'(1);
            D_RIGHT: nx = (hx_q == X_LAST) ? '0     : hx_q + XW'(1);
        endcase
`else
        unique case (pend_q)
            D_UP: begin
                if (hy_q == '0) wall = 1'b1;
                else ny = hy_q - YW'(1);
            end
            D_DOWN: begin
                if (hy_q == Y_LAST) wall = 1'b1;
                else ny = hy_q + YW'(1);
            end
            D_LEFT: begin
                if (hx_q == '0) wall = 1'b1;
                else nx = hx_q - XW'(1);
            end
            D_RIGHT: begin
                if (hx_q == X_LAST) wall = 1'b1;
                else nx = hx_q + XW'(1);
            end
        endcase
`endif
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hx_d    = hx_q;
        hy_d    = hy_q;
        dir_d   = dir_q;
        pend_d  = pend_q;
        step_d  = 1'b0;
        crash_d = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                end
            end
            S_RUN: begin
                if (tick) begin
                    cnt_d = '0;
                    dir_d = pend_q;
                    if (wall) begin
                        crash_d = 1'b1;
                        state_d = S_DEAD;
                    end else begin
                        hx_d   = nx;
                        hy_d   = ny;
                        step_d = 1'b1;
                        if (pause) state_d = S_PAUSE;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    if (pause) state_d = S_PAUSE;
                end
                if (dir_ok) pend_d = dir_in;
            end
            S_PAUSE: begin
                if (dir_ok) pend_d = dir_in;
                if (!pause) state_d = S_RUN;
            end
            S_DEAD: begin
                if (start) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                    hx_d    = X_HOME;
                    hy_d    = Y_HOME;
                    dir_d   = D_RIGHT;
                    pend_d  = D_RIGHT;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            hx_q    <= X_HOME;
            hy_q    <= Y_HOME;
            dir_q   <= D_RIGHT;
            pend_q  <= D_RIGHT;
            step_q  <= 1'b0;
            crash_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hx_q    <= hx_d;
            hy_q    <= hy_d;
            dir_q   <= dir_d;
            pend_q  <= pend_d;
            step_q  <= step_d;
            crash_q <= crash_d;
        end
    end

    assign head_x  = hx_q;
    assign head_y  = hy_q;
    assign cur_dir = dir_q;
    assign step    = step_q;
    assign crash   = crash_q;
    assign state   = state_q;

endmodule

// File: tb/tb_cobra_ctrl.sv
// Bench for cobra_ctrl: directed walk-through, then random stimulus vs a
// cycle-count reference model of the game rules.
module tb_cobra_ctrl;

    localparam int GW  = 8;
    localparam int GH  = 6;
    localparam int TD  = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, pause, dir_valid;
    logic [1:0] dir_in;
    logic [2:0] head_x, head_y;
    logic [1:0] cur_dir, state;
    logic       step, crash;

    int n_chk = 0;
    int n_bad = 0;

    int m_state, m_x, m_y, m_dir, m_pend, m_runs;
    int m_step, m_crash;

    int dx[4]  = '{0, 0, -1, 1};
    int dy[4]  = '{-1, 1, 0, 0};
    int opp[4] = '{1, 0, 3, 2};

    logic pz;

    cobra_ctrl #(
        .GRID_W(GW), .GRID_H(GH), .XW(3), .YW(3), .TICK_DIV(TD)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .pause(pause),
        .dir_valid(dir_valid), .dir_in(dir_in),
        .head_x(head_x), .head_y(head_y), .cur_dir(cur_dir),
        .step(step), .crash(crash), .state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_x     = GW / 2;
        m_y     = GH / 2;
        m_dir   = 3;
        m_pend  = 3;
        m_runs  = 0;
        m_step  = 0;
        m_crash = 0;
    endtask

    // One clock edge of game rules: a move every TD RUN cycles.
    task automatic model_step(input logic s, input logic p,
                              input logic v, input logic [1:0] d);
        int  nx, ny;
        bit  died;
        died    = 0;
        m_step  = 0;
        m_crash = 0;
        if (!rst_n) begin
            model_reset();
            return;
        end
        case (m_state)
            0: if (s) begin
                m_state = 1;
                m_runs  = 0;
            end
            1: begin
                m_runs++;
                if (m_runs == TD) begin
                    m_runs = 0;
                    m_dir  = m_pend;
                    nx = m_x + dx[m_dir];
                    ny = m_y + dy[m_dir];
`ifdef COBRA_WRAP_EN
                    m_x    = (nx + GW) % GW;
                    m_y    = (ny + GH) % GH;
                    m_step = 1;
`else
                    if (nx < 0 || nx >= GW || ny < 0 || ny >= GH) begin
                        m_crash = 1;
                        m_state = 3;
                        died    = 1;
                    end else begin
                        m_x    = nx;
                        m_y    = ny;
                        m_step = 1;
                    end
`endif
                end
                if (v && int'(d) != opp[m_dir]) m_pend = int'(d);
                if (!died && p) m_state = 2;
            end
            2: begin
                if (v && int'(d) != opp[m_dir]) m_pend = int'(d);
                if (!p) m_state = 1;
            end
            default: if (s) begin
                model_reset();
                m_state = 1;
            end
        endcase
    endtask

    task automatic compare_all();
        chk("state",   state,   m_state);
        chk("head_x",  head_x,  m_x);
        chk("head_y",  head_y,  m_y);
        chk("cur_dir", cur_dir, m_dir);
        chk("step",    step,    m_step);
        chk("crash",   crash,   m_crash);
    endtask

    task automatic do_cycle(input logic s, input logic p,
                            input logic v, input logic [1:0] d);
        start     = s;
        pause     = p;
        dir_valid = v;
        dir_in    = d;
        model_step(s, p, v, d);
        @(negedge clk);
        compare_all();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        compare_all();
        @(negedge clk);
        compare_all();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; start = 0; pause = 0; dir_valid = 0; dir_in = 0;
        pz = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_state", state, 0);
        chk("rst_x", head_x, 4);
        chk("rst_y", head_y, 3);
        chk("rst_dir", cur_dir, 3);
        compare_all();
        rst_n = 1'b1;

        do_cycle(1, 0, 0, 2'b00);
        chk("start_run", state, 1);
        for (int t = 1; t <= 3; t++) begin
            repeat (TD) do_cycle(0, 0, 0, 2'b00);
            chk("tick_step", step, 1);
            chk("tick_x", head_x, 4 + t);
            chk("tick_y", head_y, 3);
        end
        repeat (TD) do_cycle(0, 0, 0, 2'b00);
`ifdef COBRA_WRAP_EN
        chk("wrap_x", head_x, 0);
        chk("wrap_step", step, 1);
`else
        chk("dead_crash", crash, 1);
        chk("dead_state", state, 3);
        chk("dead_x", head_x, 7);
        do_cycle(1, 0, 0, 2'b00);
        chk("restart_state", state, 1);
        chk("restart_x", head_x, 4);
        chk("restart_y", head_y, 3);
`endif
        do_reset();
        do_cycle(1, 0, 0, 2'b00);
        do_cycle(0, 0, 1, 2'b10);
        repeat (TD - 1) do_cycle(0, 0, 0, 2'b00);
        chk("rev_dir", cur_dir, 3);
        do_cycle(0, 0, 1, 2'b00);
        repeat (TD - 1) do_cycle(0, 0, 0, 2'b00);
        chk("up_dir", cur_dir, 0);
        chk("up_y", head_y, 2);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 399) == 0) begin
                do_reset();
            end else begin
                if ($urandom_range(0, 15) == 0) pz = ~pz;
                do_cycle($urandom_range(0, 3) == 0, pz,
                         $urandom_range(0, 2) == 0,
                         2'($urandom_range(0, 3)));
            end
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
